mvm_stream_adapter: RTL and testbench
=====================================

Name: mvm_stream_adapter

Overview:
- Upstream/downstream adapter wrapped around mvm_20_20_8_1.
- Accepts a stalling valid/ready byte stream of one frame: K*K matrix elements (row-major), then K vector elements. Buffers the full frame because the MVM load ports cannot stall.
- Bursts the frame into the MVM using the load/start protocol, captures the K 2B-bit results, and drains them on a valid/ready output stream.

Parameters:
K, 20, matrix dimension / vector length
B, 8, input element width (signed)
GAP, 2, idle cycles inserted between load phases and before start
DONE_TO_DATA, 1, cycles from mvm_done high to first valid mvm_data_out word

Ports:
clk  in  1  clock
reset  in  1  reset
s_valid  in  1  input element valid
s_ready  out  1  adapter accepts element
s_data  in  B  signed input element
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_data  out  2B  signed result y[i]
mvm_loadMatrix  out  1  one-cycle pulse to MVM
mvm_loadVector  out  1  one-cycle pulse to MVM
mvm_start  out  1  one-cycle pulse to MVM
mvm_data_in  out  B  element to MVM
mvm_done  in  1  MVM done pulse
mvm_data_out  in  2B  MVM result stream

Behaviour:
- Clock clk; reset is synchronous, active-high.
- Reset clears the FSM to IDLE and zeroes all counters.
- Reset values: s_ready=0, m_valid=0, m_data=0, all mvm_* outputs=0.
- All mvm_* outputs are registered. mvm_data_in is 0 whenever no element is being driven.
- Constant FRAME=K*K+K.
- Input side:
  - s_ready = (wr_cnt < FRAME) && state not in {LOAD_M, LOAD_V}.
  - An element is written at buf[wr_cnt] on s_valid&&s_ready.
  - wr_cnt clears on the cycle LOAD_V completes. From then on the next frame may be collected during START/WAIT_DONE/CAPTURE/IDLE.
- FSM states: IDLE, PULSE_M, LOAD_M, GAP_M, PULSE_V, LOAD_V, GAP_V, START, WAIT_DONE, CAPTURE.
  - IDLE -> PULSE_M when wr_cnt==FRAME and the output buffer is empty.
  - PULSE_M: mvm_loadMatrix=1 for exactly one cycle.
  - LOAD_M: K*K consecutive cycles. Cycle j (0-based, first cycle directly after the pulse) drives mvm_data_in=buf[j]. No bubbles allowed.
  - GAP_M: GAP cycles, then PULSE_V (mvm_loadVector=1 for one cycle).
  - LOAD_V: K consecutive cycles, mvm_data_in=buf[K*K+j].
  - GAP_V: GAP cycles.
  - START: mvm_start=1 for one cycle, then WAIT_DONE.
  - WAIT_DONE: on mvm_done=1, wait DONE_TO_DATA cycles, then enter CAPTURE.
  - CAPTURE: K consecutive cycles; word i of mvm_data_out is written to obuf[i]. Then return to IDLE.
- A second mvm_done while in CAPTURE is ignored. mvm_done outside WAIT_DONE is ignored.
- Output side:
  - m_valid = (rd_cnt < oc_cnt); m_data = obuf[rd_cnt] (registered).
  - rd_cnt advances on m_valid&&m_ready.
  - When rd_cnt reaches K, both counts clear, which empties the buffer.
  - Draining may begin during CAPTURE once word 0 is written. m_data holds stable while m_valid&&!m_ready.
- Frame buffer read latency is 1 cycle. The FSM prefetches so that LOAD_M/LOAD_V stay gap-free.
- Arithmetic: none. Results pass through bit-exact; 2B-bit wrap is the MVM's.
- Simultaneous events:
  - An input write and a LOAD_V completion on the same cycle cannot occur, because s_ready=0 in LOAD_V.
  - An output pop on the same cycle as a capture write: both take effect.
- Reset mid-operation (any state) returns to the reset state in the next cycle. Partial frames are discarded. The MVM is also reset by the system, so no cleanup pulse is needed.

Decomposition:
- Package mvm_stream_pkg holds:
  - the state enum;
  - localparams FRAME, CNT_W=$clog2(FRAME+1), OCNT_W=$clog2(K+1);
  - element typedefs elem_t (signed B) and res_t (signed 2B).
- One sub-module, frame_buffer: a simple dual-port sync RAM, FRAME x B, 1-cycle read.
- The output buffer (K x 2B) stays inline as a register array.

Test Plan:
- Identity matrix, x=1..20, s_valid always 1:
  - mvm_loadMatrix pulse, then 400 gap-free data cycles with mvm_data_in equal to the matrix, GAP=2, loadVector pulse, 20 cycles 1..20, GAP, start pulse.
  - With the behavioural MVM model, m_data = 1..20 in order.
- Same frame with s_valid toggling randomly (50%) -> MVM-side trace cycle-identical to the gap-free case relative to the loadMatrix pulse; outputs 1..20.
- All elements -128 -> each y=20*16384=327680 mod 2^16 = 0x0000, twenty zeros. All matrix elements 1 with x[j]=-1 -> y=-20 (0xFFEC).
- m_ready held 0 for 50 cycles after first m_valid:
  - m_data stays 1 and m_valid stays 1;
  - s_ready stays 1 and the next 420 elements are accepted;
  - no PULSE_M occurs until all 20 results drain, then frame 2 loads.
- Reset asserted at LOAD_M cycle 150:
  - next cycle all mvm_* = 0, s_ready=0, m_valid=0;
  - after release, s_ready=1 and a fresh frame gives correct results.
- Spurious mvm_done in IDLE -> no capture and m_valid stays 0.

Source files
------------

// File: rtl/mvm_stream_pkg.sv
// mvm_stream_pkg: shared sizes, types and FSM states for the MVM stream adapter.
package mvm_stream_pkg;

    localparam int K            = 20;
    localparam int B            = 8;
    localparam int GAP          = 2;
    localparam int DONE_TO_DATA = 1;

    localparam int FRAME  = K * K + K;
    localparam int CNT_W  = $clog2(FRAME + 1);
    localparam int OCNT_W = $clog2(K + 1);
    localparam int ADDR_W = $clog2(FRAME);

    typedef logic signed [B-1:0]   elem_t;
    typedef logic signed [2*B-1:0] res_t;
    typedef logic [CNT_W-1:0]      cnt_t;
    typedef logic [OCNT_W-1:0]     ocnt_t;
    typedef logic [ADDR_W-1:0]     addr_t;

    localparam cnt_t  FRAME_N  = cnt_t'(FRAME);
    localparam cnt_t  MAT_LAST = cnt_t'(K * K - 1);
    localparam cnt_t  VEC_LAST = cnt_t'(K - 1);
    localparam cnt_t  VEC_PF   = cnt_t'(K - 2);
    localparam cnt_t  GAP_LAST = cnt_t'(GAP - 1);
    localparam cnt_t  DTD_LAST = cnt_t'(DONE_TO_DATA - 1);
    localparam ocnt_t O_LAST   = ocnt_t'(K - 1);

    typedef enum logic [3:0] {
        IDLE, PULSE_M, LOAD_M, GAP_M, PULSE_V, LOAD_V, GAP_V, START, WAIT_DONE, CAPTURE
    } state_t;

endpackage

// File: rtl/frame_buffer.sv
// frame_buffer: simple dual-port synchronous RAM holding one input frame, 1-cycle read.
module frame_buffer
    import mvm_stream_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [B-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [B-1:0]      rdata
);

    elem_t mem [FRAME];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mvm_stream_adapter.sv
// mvm_stream_adapter: buffers one valid/ready frame, bursts it into the MVM load ports,
// captures the K results and drains them on a valid/ready output stream.
module mvm_stream_adapter
    import mvm_stream_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [B-1:0]     s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [2*B-1:0]   m_data,
    output logic             mvm_loadMatrix,
    output logic             mvm_loadVector,
    output logic             mvm_start,
    output logic [B-1:0]     mvm_data_in,
    input  logic             mvm_done,
    input  logic [2*B-1:0]   mvm_data_out
);

    state_t state, state_n;
    cnt_t   wr_cnt, cnt, cnt_n;
    ocnt_t  oc_cnt, rd_cnt, rd_n;
    addr_t  raddr;
    elem_t  rdata;
    res_t   obuf [K];
    logic   we, loading, load_v_done, cap, pop, wait_go;

    assign loading     = state == LOAD_M || state == LOAD_V;
    assign s_ready     = !reset && wr_cnt < FRAME_N && !loading;
    assign we          = s_valid && s_ready;
    assign load_v_done = state == LOAD_V && cnt == VEC_LAST;
    assign cap         = state == CAPTURE;
    assign m_valid     = rd_cnt < oc_cnt;
    assign pop         = m_valid && m_ready;
    assign wait_go     = state == WAIT_DONE && (cnt != '0 || mvm_done);
    assign rd_n        = pop ? (rd_cnt == O_LAST ? '0 : rd_cnt + 1'b1) : rd_cnt;

    // Read address runs two cycles ahead of mvm_data_in (RAM latency + output register).
    assign raddr = state == PULSE_M ? addr_t'(1)
                 : state == LOAD_M  ? addr_t'(cnt + cnt_t'(2))
                 : state == GAP_M   ? addr_t'(K * K)
                 : state == PULSE_V ? addr_t'(K * K + 1)
                 : state == LOAD_V && cnt < VEC_PF ? addr_t'(K * K + 2) + addr_t'(cnt)
                 : '0;

    frame_buffer u_fbuf (
        .clk   (clk),
        .we    (we),
        .waddr (addr_t'(wr_cnt)),
        .wdata (s_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (wr_cnt == FRAME_N && oc_cnt == '0) state_n = PULSE_M;
            PULSE_M:   state_n = LOAD_M;
            LOAD_M:    if (cnt == MAT_LAST) state_n = GAP_M;
            GAP_M:     if (cnt == GAP_LAST) state_n = PULSE_V;
            PULSE_V:   state_n = LOAD_V;
            LOAD_V:    if (cnt == VEC_LAST) state_n = GAP_V;
            GAP_V:     if (cnt == GAP_LAST) state_n = START;
            START:     state_n = WAIT_DONE;
            WAIT_DONE: if (wait_go && cnt == DTD_LAST) state_n = CAPTURE;
            CAPTURE:   if (cnt == VEC_LAST) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // WAIT_DONE holds cnt at zero until mvm_done, then counts out the data latency.
    assign cnt_n = (state_n != state || state == IDLE || (state == WAIT_DONE && !wait_go))
                 ? '0 : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            wr_cnt         <= '0;
            oc_cnt         <= '0;
            rd_cnt         <= '0;
            m_data         <= '0;
            mvm_loadMatrix <= 1'b0;
            mvm_loadVector <= 1'b0;
            mvm_start      <= 1'b0;
            mvm_data_in    <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            wr_cnt         <= load_v_done ? '0 : wr_cnt + cnt_t'(we);
            rd_cnt         <= rd_n;
            oc_cnt         <= (pop && rd_cnt == O_LAST) ? '0 : oc_cnt + ocnt_t'(cap);
            m_data         <= (cap && oc_cnt == rd_n) ? mvm_data_out : obuf[rd_n];
            mvm_loadMatrix <= state_n == PULSE_M;
            mvm_loadVector <= state_n == PULSE_V;
            mvm_start      <= state_n == START;
            mvm_data_in    <= (state_n == LOAD_M || state_n == LOAD_V) ? rdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) obuf[oc_cnt] <= mvm_data_out;
    end

endmodule

// File: tb/tb_mvm_stream_adapter.sv
// tb_mvm_stream_adapter: directed bench with a behavioural MVM model and trace recorder.
module tb_mvm_stream_adapter;
    import mvm_stream_pkg::*;

    logic           clk = 1'b0, reset = 1'b1, s_valid = 1'b0, m_ready = 1'b0;
    logic           spur_done = 1'b0, model_done = 1'b0;
    logic [B-1:0]   s_data = '0;
    logic [2*B-1:0] mvm_data_out = '0;
    logic           s_ready, m_valid, mvm_loadMatrix, mvm_loadVector, mvm_start;
    logic [2*B-1:0] m_data;
    logic [B-1:0]   mvm_data_in;

    always #5 clk = ~clk;

    mvm_stream_adapter dut (
        .clk            (clk),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .mvm_loadMatrix (mvm_loadMatrix),
        .mvm_loadVector (mvm_loadVector),
        .mvm_start      (mvm_start),
        .mvm_data_in    (mvm_data_in),
        .mvm_done       (model_done | spur_done),
        .mvm_data_out   (mvm_data_out)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural MVM: loads on pulses, answers start with done then K result words.
    int    cyc = 0, lm_cyc = 0, lm_count = 0, lv_off = -1, st_off = -1, mi = K * K, vi = K, t = 0;
    logic  busy = 1'b0;
    elem_t mm [K*K];
    elem_t vv [K];
    res_t  yv [K];
    elem_t tlog [512];

    function automatic res_t dot(input int i);
        res_t s = '0;
        for (int j = 0; j < K; j++) s += res_t'(mm[i*K+j]) * res_t'(vv[j]);
        return s;
    endfunction

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            mi           <= K * K;
            vi           <= K;
            busy         <= 1'b0;
            model_done   <= 1'b0;
            mvm_data_out <= '0;
        end else begin
            if (mvm_loadMatrix) begin
                lm_cyc   <= cyc;
                lm_count <= lm_count + 1;
                mi       <= 0;
                tlog[0]  <= mvm_data_in;
            end else begin
                if (cyc - lm_cyc < 512) tlog[cyc-lm_cyc] <= mvm_data_in;
                if (mi < K * K) begin
                    mm[mi] <= mvm_data_in;
                    mi     <= mi + 1;
                end
            end
            if (mvm_loadVector) begin
                vi     <= 0;
                lv_off <= cyc - lm_cyc;
            end else if (vi < K) begin
                vv[vi] <= mvm_data_in;
                vi     <= vi + 1;
            end
            if (mvm_start) begin
                st_off <= cyc - lm_cyc;
                for (int i = 0; i < K; i++) yv[i] <= dot(i);
                busy <= 1'b1;
                t    <= 0;
            end else if (busy) begin
                t            <= t + 1;
                model_done   <= (t == 3 || t == 12);
                mvm_data_out <= (t >= 4 && t < 24) ? yv[t-4] : 16'h5A5A;
                busy         <= t < 25;
            end
        end
    end

    elem_t fr [FRAME];

    task automatic build(input int mode);
        for (int i = 0; i < K * K; i++)
            fr[i] = mode == 0 ? elem_t'(i / K == i % K) : mode == 1 ? elem_t'(-128) : elem_t'(1);
        for (int j = 0; j < K; j++)
            fr[K*K+j] = mode == 0 ? elem_t'(j + 1) : mode == 1 ? elem_t'(-128) : elem_t'(-1);
    endtask

    task automatic push(input elem_t v);
        int n = 0;
        s_valid = 1'b1;
        s_data  = v;
        while (!s_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("s_ready_timeout", 0, 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send(input bit toggle);
        for (int i = 0; i < FRAME; i++) begin
            if (toggle) while ($urandom_range(1) == 1) @(negedge clk);
            push(fr[i]);
        end
    endtask

    task automatic drain(input int mode);
        for (int i = 0; i < K; i++) begin
            int n = 0;
            m_ready = 1'b1;
            while (!m_valid && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 3000) begin
                chk("m_valid_timeout", 0, 1);
                m_ready = 1'b0;
                return;
            end
            chk($sformatf("m_data[%0d]", i), $signed(m_data), mode == 0 ? i + 1 : mode == 1 ? 0 : -20);
            @(negedge clk);
        end
        m_ready = 1'b0;
    endtask

    task automatic trace(input string tag);
        int e = 0;
        int z [5] = '{0, 401, 402, 424, 425};
        for (int j = 0; j < K * K; j++) if (tlog[1+j] !== fr[j]) e++;
        for (int j = 0; j < K; j++) if (tlog[404+j] !== fr[K*K+j]) e++;
        for (int j = 0; j < 5; j++) if (tlog[z[j]] !== 0) e++;
        chk({tag, "_data"}, e, 0);
        chk({tag, "_lv_off"}, lv_off, 403);
        chk({tag, "_st_off"}, st_off, 426);
    endtask

    initial begin
        int e, n, lmc;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_mvm", {mvm_loadMatrix, mvm_loadVector, mvm_start, mvm_data_in}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1);

        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        e = 0;
        repeat (30) begin
            @(negedge clk);
            if (m_valid !== 1'b0 || mvm_loadMatrix !== 1'b0) e++;
        end
        chk("spurious_done", e, 0);

        build(0); send(0); drain(0); trace("ident");
        build(0); send(1); drain(0); trace("ident_toggle");
        build(1); send(0); drain(1); trace("neg128");
        build(2); send(0); drain(2); trace("ones_neg1");

        build(0); send(0);
        n = 0;
        while (!m_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("stall_first_valid", m_valid, 1);
        lmc = lm_count;
        e = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (!s_ready || !m_valid || m_data !== 16'd1) e++;
            push(fr[i]);
        end
        chk("stall_hold", e, 0);
        chk("stall_no_pulse", lm_count, lmc);
        chk("stall_full_s_ready", s_ready, 0);
        drain(0);
        drain(0);
        chk("stall_frame2_pulse", lm_count, lmc + 1);
        trace("stall_frame2");

        build(0); send(0);
        n = 0;
        while (!mvm_loadMatrix && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_pulse", mvm_loadMatrix, 1);
        repeat (151) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_mvm", {mvm_loadMatrix, mvm_loadVector, mvm_start, mvm_data_in}, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("after_rst_s_ready", s_ready, 1);
        send(0); drain(0); trace("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
